// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and spi_module field constants
//
// Purpose : types and constants used by spi_burst_ctrl and its helpers.
// Ports   : none (package).

package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STROBE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_STORE  = 3'd4,
      ST_FIN    = 3'd5
   } state_t;

   localparam int         MODE_START_BIT  = 3;
   localparam logic [7:0] MODE_IDLE       = 8'h00;
   localparam int         STATUS_DONE_BIT = 0;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with full/empty flags
//
// Purpose : byte queue for the TX and RX paths of spi_burst_ctrl.
// Ports   : I_clk, I_rst_n (async, active-low)
//           I_wr/I_wdata  push, ignored when full unless a pop happens in the same cycle
//           I_rd          pop, ignored when empty
//           O_rdata       head entry, valid while !O_empty
//           O_full/O_empty status flags

module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_wr,
   input  logic [DATA_W-1:0] I_wdata,
   input  logic              I_rd,
   output logic [DATA_W-1:0] O_rdata,
   output logic              O_full,
   output logic              O_empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when the low bits match.
   logic [AW:0]       r_wp;
   logic [AW:0]       r_rp;
   logic              w_do_wr;
   logic              w_do_rd;

   assign O_empty = (r_wp == r_rp);
   assign O_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_do_rd = I_rd && !O_empty;
   // A same-cycle pop frees the slot being written, so a full FIFO still accepts.
   assign w_do_wr = I_wr && (!O_full || w_do_rd);
   assign O_rdata = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_do_wr) r_wp <= r_wp + 1'b1;
         if (w_do_rd) r_rp <= r_rp + 1'b1;
      end
   end

   always_ff @(posedge I_clk) begin
      if (w_do_wr) r_mem[r_wp[AW-1:0]] <= I_wdata;
   end

endmodule

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - byte sequencer feeding spi_module from host TX/RX FIFOs
//
// Purpose : runs a burst of I_len bytes through spi_module, one strobe per byte,
//           holding chip-select for the whole burst and collecting RX bytes.
// Ports   : I_clk, I_rst_n (async, active-low)
//           host  : I_tx_wr/I_tx_data/O_tx_full, I_rx_rd/O_rx_data/O_rx_empty
//           ctrl  : I_start, I_len, I_cpol_cpha, I_sck_div, O_busy, O_done, O_err
//           spi   : O_spi_tx_data, I_spi_rx_data, O_spi_mode, O_spi_sck_div, I_spi_status

module spi_burst_ctrl
   import spi_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int AW         = 4
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       I_tx_wr,
   input  logic [7:0] I_tx_data,
   output logic       O_tx_full,
   input  logic       I_rx_rd,
   output logic [7:0] O_rx_data,
   output logic       O_rx_empty,
   input  logic       I_start,
   input  logic [7:0] I_len,
   input  logic [1:0] I_cpol_cpha,
   input  logic [7:0] I_sck_div,
   output logic       O_busy,
   output logic       O_done,
   output logic       O_err,
   output logic [7:0] O_spi_tx_data,
   input  logic [7:0] I_spi_rx_data,
   output logic [7:0] O_spi_mode,
   output logic [7:0] O_spi_sck_div,
   input  logic [7:0] I_spi_status
);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_len;
   logic [1:0] r_mode;
   logic [7:0] r_div;
   logic       r_err;
   logic [7:0] r_tx_data;
   logic [7:0] r_rx_byte;
   logic       r_stat_d;
   logic       w_cpl;
   logic       w_tx_pop;
   logic       w_tx_empty;
   logic [7:0] w_tx_head;
   logic       w_rx_push;
   logic       w_rx_full;
   logic       w_unused_status;

   assign w_unused_status = |I_spi_status[7:1];
   assign w_cpl           = I_spi_status[STATUS_DONE_BIT] && !r_stat_d;

   assign O_err         = r_err;
   assign O_spi_tx_data = r_tx_data;
   assign O_spi_sck_div = r_div;

   sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH), .AW(AW)) u_tx_fifo (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_wr    (I_tx_wr),
      .I_wdata (I_tx_data),
      .I_rd    (w_tx_pop),
      .O_rdata (w_tx_head),
      .O_full  (O_tx_full),
      .O_empty (w_tx_empty)
   );

   sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH), .AW(AW)) u_rx_fifo (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_wr    (w_rx_push),
      .I_wdata (r_rx_byte),
      .I_rd    (I_rx_rd),
      .O_rdata (O_rx_data),
      .O_full  (w_rx_full),
      .O_empty (O_rx_empty)
   );

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_tx_pop   = 1'b0;
      w_rx_push  = 1'b0;
      O_spi_mode = MODE_IDLE;
      O_busy     = 1'b0;
      O_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A zero-length burst goes straight to FIN so the host still sees O_done.
            if (I_start) w_next = (I_len == 8'd0) ? ST_FIN : ST_LOAD;
         end
         ST_LOAD: begin
            w_tx_pop   = !w_tx_empty;
            O_busy     = 1'b1;
            O_spi_mode = {6'b0, r_mode};
            w_next     = ST_STROBE;
         end
         ST_STROBE: begin
            O_busy                     = 1'b1;
            O_spi_mode                 = {6'b0, r_mode};
            O_spi_mode[MODE_START_BIT] = 1'b1;
            w_next                     = ST_WAIT;
         end
         ST_WAIT: begin
            O_busy     = 1'b1;
            O_spi_mode = {6'b0, r_mode};
            if (w_cpl) w_next = ST_STORE;
         end
         ST_STORE: begin
            w_rx_push  = 1'b1;
            O_busy     = 1'b1;
            O_spi_mode = {6'b0, r_mode};
            w_next     = (r_len == 8'd1) ? ST_FIN : ST_LOAD;
         end
         ST_FIN: begin
            O_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_len     <= 8'd0;
         r_mode    <= 2'd0;
         r_div     <= 8'd0;
         r_err     <= 1'b0;
         r_tx_data <= 8'd0;
         r_rx_byte <= 8'd0;
         r_stat_d  <= 1'b0;
      end else begin
         r_stat_d <= I_spi_status[STATUS_DONE_BIT];
         case (r_state)
            ST_IDLE: begin
               if (I_start && I_len != 8'd0) begin
                  r_len  <= I_len;
                  r_mode <= I_cpol_cpha;
                  r_div  <= I_sck_div;
                  r_err  <= 1'b0;
               end
            end
            ST_LOAD: begin
               // TX underflow sends a filler byte rather than stalling the burst.
               r_tx_data <= w_tx_empty ? 8'h00 : w_tx_head;
               if (w_tx_empty) r_err <= 1'b1;
            end
            ST_WAIT: begin
               if (w_cpl) r_rx_byte <= I_spi_rx_data;
            end
            ST_STORE: begin
               r_len <= r_len - 8'd1;
               // Byte is lost only if the RX FIFO is full and the host is not popping now.
               if (w_rx_full && !I_rx_rd) r_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb/tb_spi_burst_ctrl.sv - directed self-checking bench for spi_burst_ctrl

module tb_spi_burst_ctrl;

   logic       I_clk = 1'b0;
   logic       I_rst_n = 1'b0;
   logic       I_tx_wr = 1'b0;
   logic [7:0] I_tx_data = 8'h00;
   logic       O_tx_full;
   logic       I_rx_rd = 1'b0;
   logic [7:0] O_rx_data;
   logic       O_rx_empty;
   logic       I_start = 1'b0;
   logic [7:0] I_len = 8'h00;
   logic [1:0] I_cpol_cpha = 2'd0;
   logic [7:0] I_sck_div = 8'h00;
   logic       O_busy;
   logic       O_done;
   logic       O_err;
   logic [7:0] O_spi_tx_data;
   logic [7:0] I_spi_rx_data = 8'h00;
   logic [7:0] O_spi_mode;
   logic [7:0] O_spi_sck_div;
   logic [7:0] I_spi_status = 8'h00;

   always #5 I_clk = ~I_clk;

   spi_burst_ctrl dut (
      .I_clk         (I_clk),
      .I_rst_n       (I_rst_n),
      .I_tx_wr       (I_tx_wr),
      .I_tx_data     (I_tx_data),
      .O_tx_full     (O_tx_full),
      .I_rx_rd       (I_rx_rd),
      .O_rx_data     (O_rx_data),
      .O_rx_empty    (O_rx_empty),
      .I_start       (I_start),
      .I_len         (I_len),
      .I_cpol_cpha   (I_cpol_cpha),
      .I_sck_div     (I_sck_div),
      .O_busy        (O_busy),
      .O_done        (O_done),
      .O_err         (O_err),
      .O_spi_tx_data (O_spi_tx_data),
      .I_spi_rx_data (I_spi_rx_data),
      .O_spi_mode    (O_spi_mode),
      .O_spi_sck_div (O_spi_sck_div),
      .I_spi_status  (I_spi_status)
   );

   typedef struct {
      int         npush;
      logic [7:0] len;
      logic [1:0] mode;
      logic [7:0] div;
      logic       restart;
      logic       exp_err;
      logic       keep;
   } vec_t;

   vec_t       vecs [5];
   int         n_checks = 0;
   int         n_err = 0;
   int         n_strobe = 0;
   int         n_done = 0;
   int         n_busy = 0;
   int         n_wide = 0;
   int         n_badmode = 0;
   logic       prev_stb = 1'b0;
   logic [1:0] exp_mode = 2'd0;
   logic [7:0] sent [0:1023];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] tx_byte(input int vi, input int k);
      return 8'(170 + k + 32 * vi);
   endfunction

   // Observer: strobe count/width, bytes presented at each strobe, done pulses, mode field.
   initial forever begin
      @(negedge I_clk);
      if (O_spi_mode[3]) begin
         if (prev_stb) n_wide++;
         if (n_strobe < 1024) sent[n_strobe] = O_spi_tx_data;
         n_strobe++;
      end
      prev_stb = O_spi_mode[3];
      if (O_done) n_done++;
      if (O_busy) n_busy++;
      if (O_busy && ((O_spi_mode & 8'hF7) != {6'b0, exp_mode})) n_badmode++;
   end

   // Slave model: 4 cycles after each strobe returns 8'hAA - index and pulses status bit0.
   initial begin : slave
      int cnt;
      int idx;
      cnt = 0;
      idx = 0;
      forever begin
         @(negedge I_clk);
         if (!I_rst_n) begin
            cnt = 0;
            idx = 0;
            I_spi_status = 8'h00;
         end else begin
            if (!O_busy) idx = 0;
            if (I_spi_status[0]) I_spi_status = 8'h00;
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  I_spi_rx_data = 8'hAA - 8'(idx);
                  idx++;
                  I_spi_status = 8'h01;
               end
            end
            if (O_spi_mode[3]) cnt = 4;
         end
      end
   end

   task automatic run_burst(input vec_t v, input int vi);
      int   base_s;
      int   base_d;
      int   base_b;
      int   base_w;
      int   base_m;
      logic got;
      logic [7:0] exp;
      for (int k = 0; k < v.npush; k++) begin
         I_tx_wr   = 1'b1;
         I_tx_data = tx_byte(vi, k);
         @(negedge I_clk);
      end
      I_tx_wr = 1'b0;
      chk($sformatf("v%0d_tx_full", vi), O_tx_full, v.npush == 16);
      base_s = n_strobe;
      base_d = n_done;
      base_b = n_busy;
      base_w = n_wide;
      base_m = n_badmode;
      exp_mode    = v.mode;
      I_len       = v.len;
      I_cpol_cpha = v.mode;
      I_sck_div   = v.div;
      I_start     = 1'b1;
      @(negedge I_clk);
      I_start = 1'b0;
      if (v.len == 8'd0) begin
         chk($sformatf("v%0d_zero_done_next", vi), O_done, 1);
         chk($sformatf("v%0d_zero_busy", vi), O_busy, 0);
      end else begin
         chk($sformatf("v%0d_busy_after_start", vi), O_busy, 1);
      end
      got = O_done;
      for (int c = 0; c < 3000 && !got; c++) begin
         if (v.restart && c == 10) begin
            I_start = 1'b1;
            I_len   = 8'd2;
         end else begin
            I_start = 1'b0;
         end
         @(negedge I_clk);
         if (O_done) got = 1'b1;
      end
      I_start = 1'b0;
      chk($sformatf("v%0d_done_seen", vi), got, 1);
      repeat (2) @(negedge I_clk);
      chk($sformatf("v%0d_strobes", vi), n_strobe - base_s, v.len);
      chk($sformatf("v%0d_done_count", vi), n_done - base_d, 1);
      chk($sformatf("v%0d_strobe_width", vi), n_wide - base_w, 0);
      chk($sformatf("v%0d_mode_during", vi), n_badmode - base_m, 0);
      if (v.len == 8'd0) chk($sformatf("v%0d_busy_cycles", vi), n_busy - base_b, 0);
      else               chk($sformatf("v%0d_sck_div", vi), O_spi_sck_div, v.div);
      chk($sformatf("v%0d_err", vi), O_err, v.exp_err);
      chk($sformatf("v%0d_mode_after", vi), O_spi_mode, 8'h00);
      chk($sformatf("v%0d_busy_after", vi), O_busy, 0);
      for (int k = 0; k < int'(v.len); k++) begin
         exp = (k < v.npush) ? tx_byte(vi, k) : 8'h00;
         chk($sformatf("v%0d_sent%0d", vi, k), sent[base_s + k], exp);
      end
      if (v.keep) begin
         chk($sformatf("v%0d_rx_kept", vi), O_rx_empty, 0);
      end else begin
         for (int k = 0; k < int'(v.len); k++) begin
            chk($sformatf("v%0d_rx_avail%0d", vi, k), O_rx_empty, 0);
            chk($sformatf("v%0d_rx%0d", vi, k), O_rx_data, 8'hAA - 8'(k));
            I_rx_rd = 1'b1;
            @(negedge I_clk);
            I_rx_rd = 1'b0;
         end
         chk($sformatf("v%0d_rx_empty", vi), O_rx_empty, 1);
      end
   endtask

   initial begin : main
      vec_t v;
      int   base;
      logic got;
      //            npush len    mode  div    restart exp_err keep
      vecs[0] = '{3, 8'd3, 2'd3, 8'd8, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{0, 8'd0, 2'd1, 8'd2, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1, 8'd2, 2'd2, 8'd4, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{2, 8'd2, 2'd0, 8'd1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{0, 8'd5, 2'd1, 8'd3, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge I_clk);
      chk("rst_busy", O_busy, 0);
      chk("rst_done", O_done, 0);
      chk("rst_err", O_err, 0);
      chk("rst_mode", O_spi_mode, 8'h00);
      chk("rst_div", O_spi_sck_div, 8'h00);
      chk("rst_txd", O_spi_tx_data, 8'h00);
      chk("rst_tx_full", O_tx_full, 0);
      chk("rst_rx_empty", O_rx_empty, 1);
      I_rst_n = 1'b1;
      @(negedge I_clk);

      for (int i = 0; i < 5; i++) run_burst(vecs[i], i);

      // RX overflow: fill all 16 entries, then one more byte must be dropped.
      v = '{16, 8'd16, 2'd0, 8'd2, 1'b0, 1'b0, 1'b1};
      run_burst(v, 5);
      v = '{1, 8'd1, 2'd1, 8'd2, 1'b0, 1'b1, 1'b1};
      run_burst(v, 6);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("ovf_rx_avail%0d", k), O_rx_empty, 0);
         chk($sformatf("ovf_rx%0d", k), O_rx_data, 8'hAA - 8'(k));
         I_rx_rd = 1'b1;
         @(negedge I_clk);
         I_rx_rd = 1'b0;
      end
      chk("ovf_rx_empty", O_rx_empty, 1);

      // Reset during WAIT of byte 2 of a 4-byte burst.
      for (int k = 0; k < 4; k++) begin
         I_tx_wr   = 1'b1;
         I_tx_data = 8'(17 * (k + 1));
         @(negedge I_clk);
      end
      I_tx_wr     = 1'b0;
      base        = n_strobe;
      exp_mode    = 2'd2;
      I_len       = 8'd4;
      I_cpol_cpha = 2'd2;
      I_sck_div   = 8'd6;
      I_start     = 1'b1;
      @(negedge I_clk);
      I_start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 500 && !got; c++) begin
         @(negedge I_clk);
         if (n_strobe >= base + 2) got = 1'b1;
      end
      chk("rst_mid_reach_byte2", got, 1);
      @(negedge I_clk);
      chk("rst_mid_pre_busy", O_busy, 1);
      chk("rst_mid_pre_rx", O_rx_empty, 0);
      #2 I_rst_n = 1'b0;
      #1;
      chk("rst_mid_mode", O_spi_mode, 8'h00);
      chk("rst_mid_busy", O_busy, 0);
      chk("rst_mid_rx_empty", O_rx_empty, 1);
      chk("rst_mid_txd", O_spi_tx_data, 8'h00);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      @(negedge I_clk);
      v = '{1, 8'd1, 2'd2, 8'd5, 1'b0, 1'b0, 1'b0};
      run_burst(v, 7);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
- Byte-sequencing front end that sits directly upstream of spi_module. It feeds that module's TX data, mode, and SCK-divider inputs, and consumes its RX data and status.
- Host software pushes bytes into a TX FIFO and issues a burst command. The controller strobes spi_module once per byte and collects received bytes into an RX FIFO.
- Chip-select is held active for the whole burst and released at the end.

Parameters:
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; must be a power of 2.
- AW, 4, FIFO address width; equals log2(FIFO_DEPTH).

Ports:
- I_clk  in  1  system clock; the same clock as spi_module I_CLK.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_tx_wr  in  1  push I_tx_data into the TX FIFO; ignored when full.
- I_tx_data  in  8  host TX byte.
- O_tx_full  out  1  TX FIFO full.
- I_rx_rd  in  1  pop the RX FIFO; ignored when empty.
- O_rx_data  out  8  RX FIFO head (show-ahead); valid when !O_rx_empty.
- O_rx_empty  out  1  RX FIFO empty.
- I_start  in  1  one-cycle burst command; ignored while O_busy.
- I_len  in  8  burst length in bytes, 1..255; 0 is a no-op.
- I_cpol_cpha  in  2  SPI mode for the burst; captured at I_start.
- I_sck_div  in  8  SCK divider; captured at I_start.
- O_busy  out  1  burst in progress.
- O_done  out  1  one-cycle pulse at the end of a burst.
- O_err  out  1  sticky error (TX underflow or RX overflow); cleared by the next accepted I_start.
- O_spi_tx_data  out  8  to spi_module I_TX_DATA.
- I_spi_rx_data  in  8  from spi_module O_RX_DATA.
- O_spi_mode  out  8  to spi_module I_SPI_MODE.
- O_spi_sck_div  out  8  to spi_module I_SPI_SCK_DIV.
- I_spi_status  in  8  from spi_module O_SPI_STATUS; bit0 = byte complete.

Behaviour:
- Reset values: all outputs 0, except O_rx_empty = 1. Both FIFOs are emptied and the FSM goes to IDLE.
- spi_module mode encoding:
  - bits[1:0] = CPOL/CPHA.
  - bit3 = byte-start strobe.
  - 8'h00 = idle, with CS released.
  - Bits [7:4] and [2] are always 0.
- spi_module handshake:
  - Byte completion is the rising edge of I_spi_status[0], detected against a registered copy.
  - A completion seen outside WAIT is ignored.
- FSM states:
  - IDLE: wait for I_start.
    - On I_start with I_len == 0: pulse O_done the next cycle; O_busy stays 0.
    - On I_start with I_len != 0: latch len, mode, and div; clear O_err; set O_busy; go to LOAD.
  - LOAD:
    - If TX FIFO is empty: set O_err, send 8'h00 instead, and continue (the burst is never stalled).
    - Otherwise pop the TX head into O_spi_tx_data.
    - O_spi_mode = {4'b0, 1'b0, 1'b0, mode}. Go to STROBE.
  - STROBE: O_spi_mode bit3 = 1 for exactly one I_clk, then return to 0. Go to WAIT.
  - WAIT: on a completion edge, capture I_spi_rx_data and go to STORE.
  - STORE:
    - Push the captured byte to the RX FIFO. If the RX FIFO is full, drop the byte and set O_err.
    - Decrement the remaining count. If nonzero, go to LOAD; else go to FIN.
  - FIN: O_spi_mode = 8'h00, O_busy = 0, O_done = 1 for one cycle. Go to IDLE.
- O_spi_sck_div: holds the latched divider from I_start until the next accepted I_start.
- Byte-to-byte gap: 3 I_clk cycles (LOAD, STROBE, and STORE overhead) plus the spi_module byte time.
- Simultaneous FIFO events:
  - Host push and controller pop in the same cycle on the TX FIFO: both take effect, and the count is unchanged.
  - Host pop and controller push in the same cycle on the RX FIFO: both take effect.
  - A full RX FIFO with a same-cycle host pop accepts the push.
- FIFO pointers: AW+1 bits wrapping modulo 2*FIFO_DEPTH.
  - full = MSBs differ and the lower bits are equal.
  - empty = pointers equal.
- Reset mid-burst: an immediate asynchronous return to the reset state. O_spi_mode goes to 00, releasing CS; FIFO contents are discarded.
- I_start while busy: ignored, with no effect on O_err.

Decomposition:
- Package spi_pkg:
  - FSM state encoding (IDLE, LOAD, STROBE, WAIT, STORE, FIN).
  - Mode bit constants: MODE_START_BIT = 3, MODE_IDLE = 8'h00.
  - STATUS_DONE_BIT = 0.
- Sub-module sync_fifo (DATA_W, DEPTH): show-ahead, single clock, full/empty flags. It is instantiated twice, once for TX and once for RX.

Test Plan:
- Push AA,AB,AC; I_start with len = 3, cpol_cpha = 3, div = 8; model slave returns AA,A9,A8 → three bit3 strobes, each one cycle wide; mode = 03 during the burst; O_done pulses once; RX pops AA,A9,A8; O_err = 0; mode = 00 after.
- len = 0 start → O_done pulses next cycle; no bit3 strobe; O_busy stays 0.
- Push 1 byte, start with len = 2 → second byte sends 00; O_err = 1; 2 RX entries stored; next start clears O_err.
- Fill RX with 16 bytes (no reads), run len = 1 → RX byte dropped; O_err = 1; RX count stays 16.
- Assert I_rst_n = 0 during WAIT of byte 2 of 4 → mode = 00, O_busy = 0, O_rx_empty = 1 immediately; after release, a new len = 1 burst completes normally.
- I_start pulsed during an active burst with len = 5 → ignored; the original burst length is unchanged; exactly one O_done.
